// File: rtl/equal_segmentation_adder_32.sv
`default_nettype none
// ============================================================================
// Module      : equal_segmentation_adder_32
// Description : Approximate adder. Equal-width segments are added independently
//               and the inter-segment carries are dropped; output is registered.
// Revision    : 1.0
// ============================================================================
module equal_segmentation_adder_32 #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  output logic [WIDTH:0]   result_o,
  output logic             out_valid_o
);

  localparam int c_num_seg = WIDTH / SEG_W;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] r_result;
  logic           r_valid;

  // Each segment is its own adder; no carry ever crosses a segment boundary.
  for (genvar k = 0; k < c_num_seg; k++) begin : g_seg
    logic [SEG_W:0] w_seg_sum;

    assign w_seg_sum = {1'b0, add1_i[k*SEG_W +: SEG_W]}
                     + {1'b0, add2_i[k*SEG_W +: SEG_W]};
    assign w_sum[k*SEG_W +: SEG_W] = w_seg_sum[SEG_W-1:0];

    if (k == c_num_seg - 1) begin : g_top
      assign w_sum[WIDTH] = w_seg_sum[SEG_W];
    end else begin : g_drop
      logic w_unused_carry;
      assign w_unused_carry = w_seg_sum[SEG_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid_i;
      if (in_valid_i) begin
        r_result <= w_sum;
      end
    end
  end

  assign result_o    = r_result;
  assign out_valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_equal_segmentation_adder_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_equal_segmentation_adder_32
// Description : Self-checking bench for the equal-segmentation approximate adder.
// Revision    : 1.0
// ============================================================================
module tb_equal_segmentation_adder_32;

  localparam int WIDTH = 32;
  localparam int SEG_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid_i;
  logic [WIDTH-1:0] add1_i;
  logic [WIDTH-1:0] add2_i;
  logic [WIDTH:0]   result_o;
  logic             out_valid_o;

  int total = 0;
  int bad   = 0;

  equal_segmentation_adder_32 #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .add1_i     (add1_i),
    .add2_i     (add2_i),
    .result_o   (result_o),
    .out_valid_o(out_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: per-segment sums with plain integer arithmetic, lower carries discarded.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint unsigned acc = 0;
    longint unsigned base, sa, sb, s;
    for (int k = 0; k < WIDTH / SEG_W; k++) begin
      base = 64'd1 << (k * SEG_W);
      sa = (longint'(a) / base) % (64'd1 << SEG_W);
      sb = (longint'(b) / base) % (64'd1 << SEG_W);
      s  = sa + sb;
      if (k != WIDTH / SEG_W - 1) s = s % (64'd1 << SEG_W);
      acc = acc + s * base;
    end
    return acc[WIDTH:0];
  endfunction

  task automatic check(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one valid vector, then check result and valid just after the edge.
  task automatic vec(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [WIDTH:0] exp);
    @(negedge clk);
    in_valid_i = 1'b1;
    add1_i     = a;
    add2_i     = b;
    @(posedge clk);
    #1;
    check(tag, result_o, exp);
    check({tag, "_valid"}, {{WIDTH{1'b0}}, out_valid_o}, 33'd1);
  endtask

  logic [WIDTH:0]   exp_res;
  logic             exp_vld;
  logic [WIDTH-1:0] ra, rb;
  logic             rv;

  initial begin
    rst_n      = 1'b0;
    in_valid_i = 1'b0;
    add1_i     = '0;
    add2_i     = '0;
    #12;
    check("reset_result", result_o, 33'd0);
    check("reset_valid", {32'd0, out_valid_o}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", {out_valid_o, result_o}, 34'd0);

    // Directed vectors from the behavioural rules.
    vec("no_carry",   32'h29AF2430, 32'h7A1B9ABC, 33'h0_A3CABEEC);
    vec("drop1",      32'h20202012, 32'hDEADBEEF, 33'h0_FECDDE01);
    vec("drop_lsb",   32'h00000001, 32'hDEAFBEEF, 33'h0_DEAFBEF0);
    vec("multi_drop", 32'h8943DEAF, 32'hDAADBAAD, 33'h1_63F0985C);
    vec("cout",       32'h80519860, 32'h8086BA3E, 33'h1_00D7529E);
    vec("alt_bits",   32'h55555555, 32'hAAAAAAAA, 33'h0_FFFFFFFF);
    vec("all_ones",   32'hFFFFFFFF, 32'h00000001, 33'h0_FFFFFF00);
    vec("zero",       32'h00000000, 32'h00000000, 33'h0_00000000);

    // Three back-to-back valid vectors, then idle: result must hold.
    vec("burst0", 32'h01020304, 32'h10203040, 33'h0_11223344);
    vec("burst1", 32'hFF00FF00, 32'h01010101, 33'h1_00010001);
    vec("burst2", 32'h12345678, 32'h9ABCDEF0, 33'h0_ACF03468);
    @(negedge clk);
    in_valid_i = 1'b0;
    add1_i     = 32'hDEADDEAD;
    add2_i     = 32'hBEEFBEEF;
    @(posedge clk);
    #1;
    check("idle_valid", {32'd0, out_valid_o}, 33'd0);
    check("idle_hold", result_o, 33'h0_ACF03468);

    // Asynchronous reset in the middle of a cycle with a live result.
    vec("pre_reset", 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1_FEFEFEFE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_result", result_o, 33'd0);
    check("async_rst_valid", {32'd0, out_valid_o}, 33'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    in_valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_idle", {out_valid_o, result_o}, 34'd0);

    // Randomized traffic with valid toggling, against the reference model.
    exp_res = '0;
    exp_vld = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = ~ra + 32'($urandom_range(0, 3));
      rv = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      in_valid_i = rv;
      add1_i     = ra;
      add2_i     = rb;
      @(posedge clk);
      #1;
      exp_vld = rv;
      if (rv) exp_res = ref_sum(ra, rb);
      check("rand_result", result_o, exp_res);
      check("rand_valid", {32'd0, out_valid_o}, {32'd0, exp_vld});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
